// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - two-road traffic light phase sequencer with pedestrian walk
// Tick prescaler drives a per-phase timer; lamps decode straight from the registered phase.
module traffic_phase_scheduler #(
    parameter int TICK_DIV       = 50000000,
    parameter int GREEN_MAIN_MIN = 30,
    parameter int GREEN_SIDE     = 20,
    parameter int YELLOW         = 4,
    parameter int ALL_RED        = 2,
    parameter int PED_WALK       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] light_main,
    output logic [2:0] light_side,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam int PW    = $clog2(TICK_DIV);
    localparam int MAX_A = (GREEN_MAIN_MIN > GREEN_SIDE) ? GREEN_MAIN_MIN : GREEN_SIDE;
    localparam int MAX_B = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_D = (MAX_C > PED_WALK) ? MAX_C : PED_WALK;
    localparam int TW    = $clog2(MAX_D + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_MAIN     = TW'(GREEN_MAIN_MIN - 1);
    localparam logic [TW-1:0] T_SIDE     = TW'(GREEN_SIDE - 1);
    localparam logic [TW-1:0] T_YEL      = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_RED      = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] T_WALK     = TW'(PED_WALK - 1);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        PED_WALK_ST = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_presc;
    logic [TW-1:0]   r_timer;
    logic            r_ped_pending;
    logic            w_tick;
    logic            w_main_sat;
    logic            w_walk_exit;

    assign w_tick      = (r_presc == PRESC_LAST);
    assign w_main_sat  = (r_state == MAIN_GREEN) && (r_timer >= T_MAIN);
    assign w_walk_exit = (r_state == PED_WALK_ST) && (w_next != PED_WALK_ST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_GREEN:  if (w_tick && w_main_sat && (side_req || r_ped_pending)) w_next = MAIN_YELLOW;
            MAIN_YELLOW: if (w_tick && r_timer == T_YEL)  w_next = ALL_RED_1;
            ALL_RED_1:   if (w_tick && r_timer == T_RED)  w_next = r_ped_pending ? PED_WALK_ST : SIDE_GREEN;
            PED_WALK_ST: if (w_tick && r_timer == T_WALK) w_next = side_req ? SIDE_GREEN : ALL_RED_2;
            SIDE_GREEN:  if (w_tick && r_timer == T_SIDE) w_next = SIDE_YELLOW;
            SIDE_YELLOW: if (w_tick && r_timer == T_YEL)  w_next = ALL_RED_2;
            ALL_RED_2:   if (w_tick && r_timer == T_RED)  w_next = MAIN_GREEN;
            default:     w_next = MAIN_GREEN;
        endcase
    end

    // The prescaler free-runs across phase changes so every phase spans whole ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= MAIN_GREEN;
            r_presc       <= '0;
            r_timer       <= '0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state <= w_next;
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (w_tick && !w_main_sat) begin
                r_timer <= r_timer + TW'(1);
            end
            if (ped_req) begin
                r_ped_pending <= 1'b1;
            end else if (w_walk_exit) begin
                r_ped_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        light_main = 3'b100;
        light_side = 3'b100;
        case (r_state)
            MAIN_GREEN:  light_main = 3'b001;
            MAIN_YELLOW: light_main = 3'b010;
            SIDE_GREEN:  light_side = 3'b001;
            SIDE_YELLOW: light_side = 3'b010;
            default:     ;
        endcase
    end

    assign ped_walk    = (r_state == PED_WALK_ST);
    assign ped_pending = r_ped_pending;
    assign phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scenario table plus scoreboard of expected phase segments
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] light_main;
    logic [2:0] light_side;
    logic       ped_walk;
    logic       ped_pending;
    logic [2:0] phase;

    traffic_phase_scheduler #(
        .TICK_DIV(4), .GREEN_MAIN_MIN(3), .GREEN_SIDE(2),
        .YELLOW(2), .ALL_RED(1), .PED_WALK(2)
    ) dut (
        .clk(clk), .reset(reset), .side_req(side_req), .ped_req(ped_req),
        .light_main(light_main), .light_side(light_side), .ped_walk(ped_walk),
        .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct { int ph; int dur; } seg_t;
    typedef struct { bit side; bit ped; int budget; int walk_cycles; int first_seg; } scen_t;

    seg_t  seg_tab[$];
    scen_t scen_tab[$];
    seg_t  sb_q[$];
    int    pass_cnt = 0;
    int    total_cnt = 0;

    task automatic check(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    function automatic logic [5:0] decode(input int ph);
        case (ph)
            0:       return {3'b001, 3'b100};
            1:       return {3'b010, 3'b100};
            3:       return {3'b100, 3'b001};
            4:       return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic add_scen(input bit side, input bit ped, input int budget, input int walk);
        scen_t s;
        s.side = side; s.ped = ped; s.budget = budget; s.walk_cycles = walk;
        s.first_seg = seg_tab.size();
        scen_tab.push_back(s);
    endtask

    task automatic add_seg(input int ph, input int dur);
        seg_t e;
        e.ph = ph; e.dur = dur;
        seg_tab.push_back(e);
    endtask

    task automatic do_reset(input bit side, input bit ped);
        @(posedge clk); #1;
        reset = 1'b1; side_req = side; ped_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; ped_req = ped;
    endtask

    task automatic check_cycle(input int exp_ph);
        logic [5:0] exp;
        exp = decode(exp_ph);
        check("light_main", light_main, exp[5:3]);
        check("light_side", light_side, exp[2:0]);
        check("ped_walk", ped_walk, (exp_ph == 6) ? 1 : 0);
        check("safety", ((light_main == 3'b100 || light_side == 3'b100) &&
                         (!ped_walk || (light_main == 3'b100 && light_side == 3'b100))) ? 1 : 0, 1);
    endtask

    task automatic wait_phase(input int ph, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (phase == 3'(ph)) break;
        end
    endtask

    task automatic run_scenario(input int idx);
        scen_t s;
        seg_t  e;
        seg_t  f;
        int    last, cur, cnt, walk, exp_ph;
        bit    done, final_expected;
        s = scen_tab[idx];
        last = (idx + 1 < scen_tab.size()) ? scen_tab[idx + 1].first_seg : seg_tab.size();
        sb_q.delete();
        for (int i = s.first_seg; i < last; i++) sb_q.push_back(seg_tab[i]);
        final_expected = (seg_tab[last - 1].dur == 0);
        do_reset(s.side, s.ped);
        walk = 0; done = 0; cur = 0; cnt = 0; exp_ph = sb_q[0].ph;
        for (int cyc = 0; cyc < s.budget && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) ped_req = 1'b0;
            if (cyc == 0) begin
                check("reset_pending", ped_pending, 0);
                check("start_phase", phase, sb_q[0].ph);
                cur = phase; cnt = 1;
            end else if (phase == 3'(cur)) begin
                cnt++;
            end else begin
                e = sb_q.pop_front();
                check("seg_phase", cur, e.ph);
                check("seg_len", cnt, e.dur);
                cur = phase; cnt = 1;
                if (sb_q.size() > 0) exp_ph = sb_q[0].ph;
                if (sb_q.size() == 1 && sb_q[0].dur == 0) begin
                    f = sb_q.pop_front();
                    check("final_phase", phase, f.ph);
                    done = 1;
                end
            end
            if (cyc == 1 && s.ped) check("pending_set", ped_pending, 1);
            if (ped_walk) walk++;
            check_cycle(exp_ph);
        end
        if (final_expected) check("final_reached", done, 1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.dur != 0) begin
                check("seg_phase", cur, e.ph);
                check("seg_len", cnt, e.dur);
            end
        end
        check("walk_cycles", walk, s.walk_cycles);
        if (s.ped) check("pending_cleared", ped_pending, 0);
    endtask

    initial begin
        int cnt;
        add_scen(0, 0, 200, 0);
        add_seg(0, 200);
        add_scen(1, 0, 80, 0);
        add_seg(0, 12); add_seg(1, 8); add_seg(2, 4); add_seg(3, 8);
        add_seg(4, 8);  add_seg(5, 4); add_seg(0, 0);
        add_scen(0, 1, 80, 8);
        add_seg(0, 12); add_seg(1, 8); add_seg(2, 4); add_seg(6, 8);
        add_seg(5, 4);  add_seg(0, 0);
        add_scen(1, 1, 100, 8);
        add_seg(0, 12); add_seg(1, 8); add_seg(2, 4); add_seg(6, 8);
        add_seg(3, 8);  add_seg(4, 8); add_seg(5, 4); add_seg(0, 0);

        for (int i = 0; i < scen_tab.size(); i++) run_scenario(i);

        // Reset mid SIDE_GREEN, with a simultaneous button press that reset must override.
        do_reset(1, 0);
        wait_phase(3, 60);
        check("reached_side_green", phase, 3);
        reset = 1'b1; ped_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; ped_req = 1'b0;
        @(negedge clk);
        check("rst_mid_main", light_main, 3'b001);
        check("rst_mid_side", light_side, 3'b100);
        check("rst_mid_phase", phase, 0);
        check("rst_mid_pending", ped_pending, 0);
        check("rst_mid_walk", ped_walk, 0);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (phase != 3'd0) break;
            cnt++;
        end
        check("main_green_min_len", (cnt >= 12) ? 1 : 0, 1);
        check("main_green_left", phase, 1);

        // Button pressed in the exit cycle of the walk phase: the new request must survive.
        do_reset(0, 1);
        @(negedge clk);
        @(negedge clk);
        ped_req = 1'b0;
        wait_phase(6, 60);
        check("reached_walk", phase, 6);
        repeat (7) @(negedge clk);
        check("walk_last_cycle", phase, 6);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        check("walk_exit_phase", phase, 5);
        check("pending_set_wins", ped_pending, 1);
        wait_phase(6, 80);
        check("second_walk", phase, 6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
